// File: rtl/mac_seg_rx_to_mfb_if.sv
// ---------------------------------------------------------------------------
// mac_seg_rx_to_mfb_if
//
// Purpose : Bundles the F-Tile MAC segmented RX stream (input side) and the
//           NDK MFB stream (output side) of mac_seg_rx_to_mfb.
//
// Signals : RX_MAC_DATA/INFRAME/EOP_EMPTY/FCS_ERROR/ERROR/VALID - MAC segments
//           TX_MFB_DATA/SOF/EOF/SOF_POS/EOF_POS/ERROR/SRC_RDY  - MFB word
//
// Modports: slave  - the converter (consumes MAC segments, produces MFB)
//           master - the environment (drives MAC segments, observes MFB)
// ---------------------------------------------------------------------------
interface mac_seg_rx_to_mfb_if #(
    parameter int SEGMENTS    = 4,
    parameter int REGIONS     = 1,
    parameter int REGION_SIZE = 4
);
    localparam int SOF_POS_W = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
    localparam int EOF_POS_W = $clog2(REGION_SIZE * 8);

    logic [SEGMENTS*64-1:0]          RX_MAC_DATA;
    logic [SEGMENTS-1:0]             RX_MAC_INFRAME;
    logic [SEGMENTS*3-1:0]           RX_MAC_EOP_EMPTY;
    logic [SEGMENTS-1:0]             RX_MAC_FCS_ERROR;
    logic [SEGMENTS*2-1:0]           RX_MAC_ERROR;
    logic                            RX_MAC_VALID;

    logic [SEGMENTS*64-1:0]          TX_MFB_DATA;
    logic [REGIONS-1:0]              TX_MFB_SOF;
    logic [REGIONS-1:0]              TX_MFB_EOF;
    logic [REGIONS*SOF_POS_W-1:0]    TX_MFB_SOF_POS;
    logic [REGIONS*EOF_POS_W-1:0]    TX_MFB_EOF_POS;
    logic [REGIONS-1:0]              TX_MFB_ERROR;
    logic                            TX_MFB_SRC_RDY;

    modport slave (
        input  RX_MAC_DATA, RX_MAC_INFRAME, RX_MAC_EOP_EMPTY,
               RX_MAC_FCS_ERROR, RX_MAC_ERROR, RX_MAC_VALID,
        output TX_MFB_DATA, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS,
               TX_MFB_EOF_POS, TX_MFB_ERROR, TX_MFB_SRC_RDY
    );

    modport master (
        output RX_MAC_DATA, RX_MAC_INFRAME, RX_MAC_EOP_EMPTY,
               RX_MAC_FCS_ERROR, RX_MAC_ERROR, RX_MAC_VALID,
        input  TX_MFB_DATA, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS,
               TX_MFB_EOF_POS, TX_MFB_ERROR, TX_MFB_SRC_RDY
    );
endinterface

// File: rtl/mac_seg_rx_to_mfb.sv
// ---------------------------------------------------------------------------
// mac_seg_rx_to_mfb
//
// Purpose : Converts the F-Tile MAC segmented RX stream into an NDK MFB
//           stream. SOP/EOP are derived from inframe transitions, errored
//           frames are flagged at EOF, and after reset the output stays
//           silent until a frame boundary has been observed.
//           Two-stage pipeline, fixed latency of 2 cycles, 1 word/cycle.
//
// Ports   : CLK, RESET  - clock, asynchronous active-high reset
//           bus (slave) - MAC segment input / MFB output bundle
//           PROTO_ERR   - sticky: more than one SOP or EOP in a region
//           CNT_CLEAR, CNT_FRAMES, CNT_ERRORS - frame/error counters,
//                         present only when MAC_SEG_RX_STATS_EN is defined
//
// Options : `define MAC_SEG_RX_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module mac_seg_rx_to_mfb #(
    parameter int SEGMENTS    = 4,
    parameter int REGIONS     = 1,
    parameter int REGION_SIZE = 4,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    mac_seg_rx_to_mfb_if.slave    bus,
`ifdef MAC_SEG_RX_STATS_EN
    input  logic                  CNT_CLEAR,
    output logic [63:0]           CNT_FRAMES,
    output logic [63:0]           CNT_ERRORS,
`endif
    output logic                  PROTO_ERR
);
    localparam int SEG_W     = BLOCK_SIZE * ITEM_WIDTH;
    localparam int EMPTY_W   = $clog2(BLOCK_SIZE);
    localparam int SOF_POS_W = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
    localparam int EOF_POS_W = $clog2(REGION_SIZE * BLOCK_SIZE);

    // Lowest SOP block index inside one region.
    function automatic logic [SOF_POS_W-1:0] sof_pos_enc(input logic [REGION_SIZE-1:0] sop);
        logic [SOF_POS_W-1:0] pos;
        pos = '0;
        for (int j = REGION_SIZE - 1; j >= 0; j--)
            if (sop[j]) pos = SOF_POS_W'(j);
        return pos;
    endfunction

    // Last valid byte of the EOP block: block*BLOCK_SIZE + BLOCK_SIZE-1 - empty.
    function automatic logic [EOF_POS_W-1:0] eof_pos_enc(input logic [REGION_SIZE-1:0]         eop,
                                                         input logic [REGION_SIZE*EMPTY_W-1:0] empty);
        logic [EOF_POS_W-1:0] pos;
        pos = '0;
        for (int j = REGION_SIZE - 1; j >= 0; j--)
            if (eop[j])
                pos = EOF_POS_W'(BLOCK_SIZE * j + BLOCK_SIZE - 1 - int'(empty[j*EMPTY_W +: EMPTY_W]));
        return pos;
    endfunction

    // Error bit taken from the EOP segment only.
    function automatic logic eop_err_sel(input logic [REGION_SIZE-1:0] eop,
                                         input logic [REGION_SIZE-1:0] err);
        logic sel;
        sel = 1'b0;
        for (int j = REGION_SIZE - 1; j >= 0; j--)
            if (eop[j]) sel = err[j];
        return sel;
    endfunction

    function automatic logic multi_hot(input logic [REGION_SIZE-1:0] v);
        int n;
        n = 0;
        for (int j = 0; j < REGION_SIZE; j++) n += int'(v[j]);
        return n > 1;
    endfunction

    typedef enum logic {SYNC, RUN} state_t;
    state_t state, state_next;

    logic                         prev_inframe;
    // prev_inframe holds its reset value until the first valid word; in SYNC
    // that value is not evidence of an idle line, so segment 0 may only open
    // the output once a real word has been seen.
    logic                         prev_seen;
    logic [SEGMENTS-1:0]          prev_vec, sop_raw, eop_raw, sync_qual, seg_mask, seg_err;
    logic                         hit, emit;

    logic                         vld_p1;
    logic [SEGMENTS*SEG_W-1:0]    data_p1;
    logic [SEGMENTS-1:0]          sop_p1, eop_p1, err_p1;
    logic [SEGMENTS*EMPTY_W-1:0]  empty_p1;

    logic [REGIONS-1:0]           sof_c, eof_c, err_c;
    logic [REGIONS*SOF_POS_W-1:0] sof_pos_c;
    logic [REGIONS*EOF_POS_W-1:0] eof_pos_c;
    logic                         multi_c;

    logic                         vld_p2, proto_err;
    logic [REGIONS-1:0]           sof_p2, eof_p2, err_p2;
    logic [SEGMENTS*SEG_W-1:0]    data_p2;
    logic [REGIONS*SOF_POS_W-1:0] sof_pos_p2;
    logic [REGIONS*EOF_POS_W-1:0] eof_pos_p2;

    always_comb begin
        prev_vec    = '0;
        prev_vec[0] = prev_inframe;
        for (int i = 1; i < SEGMENTS; i++) prev_vec[i] = bus.RX_MAC_INFRAME[i-1];
        sync_qual    = ~prev_vec;
        sync_qual[0] = ~prev_inframe & prev_seen;
        for (int i = 0; i < SEGMENTS; i++)
            seg_err[i] = bus.RX_MAC_FCS_ERROR[i] | (|bus.RX_MAC_ERROR[2*i +: 2]);
    end

    assign sop_raw = ~prev_vec & bus.RX_MAC_INFRAME;
    assign eop_raw = prev_vec & ~bus.RX_MAC_INFRAME;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= SYNC;
        else       state <= state_next;
    end

    // In SYNC the word is opened at the first segment preceded by an idle
    // segment; everything before it belongs to a frame cut by reset.
    always_comb begin
        state_next = state;
        seg_mask   = '1;
        emit       = bus.RX_MAC_VALID;
        hit        = 1'b0;
        if (state == SYNC) begin
            for (int i = 0; i < SEGMENTS; i++) begin
                hit         = hit | sync_qual[i];
                seg_mask[i] = hit;
            end
            emit = bus.RX_MAC_VALID & hit;
            if (emit) state_next = RUN;
        end
    end

    // ---- stage 1: register inputs and masked SOP/EOP vectors ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_inframe <= 1'b0;
            prev_seen    <= 1'b0;
            vld_p1       <= 1'b0;
        end else begin
            vld_p1 <= emit;
            if (bus.RX_MAC_VALID) begin
                prev_inframe <= bus.RX_MAC_INFRAME[SEGMENTS-1];
                prev_seen    <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (bus.RX_MAC_VALID) begin
            data_p1  <= bus.RX_MAC_DATA;
            sop_p1   <= sop_raw & seg_mask;
            eop_p1   <= eop_raw & seg_mask;
            err_p1   <= seg_err;
            empty_p1 <= bus.RX_MAC_EOP_EMPTY;
        end
    end

    // ---- stage 2: per-region position encoding, output registers ----
    always_comb begin
        sof_c     = '0;
        eof_c     = '0;
        err_c     = '0;
        sof_pos_c = '0;
        eof_pos_c = '0;
        multi_c   = 1'b0;
        for (int r = 0; r < REGIONS; r++) begin
            sof_c[r] = vld_p1 & (|sop_p1[r*REGION_SIZE +: REGION_SIZE]);
            eof_c[r] = vld_p1 & (|eop_p1[r*REGION_SIZE +: REGION_SIZE]);
            err_c[r] = eof_c[r] & eop_err_sel(eop_p1[r*REGION_SIZE +: REGION_SIZE],
                                              err_p1[r*REGION_SIZE +: REGION_SIZE]);
            sof_pos_c[r*SOF_POS_W +: SOF_POS_W] = sof_pos_enc(sop_p1[r*REGION_SIZE +: REGION_SIZE]);
            eof_pos_c[r*EOF_POS_W +: EOF_POS_W] =
                eof_pos_enc(eop_p1[r*REGION_SIZE +: REGION_SIZE],
                            empty_p1[r*REGION_SIZE*EMPTY_W +: REGION_SIZE*EMPTY_W]);
            multi_c = multi_c | (vld_p1 & (multi_hot(sop_p1[r*REGION_SIZE +: REGION_SIZE]) |
                                           multi_hot(eop_p1[r*REGION_SIZE +: REGION_SIZE])));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_p2    <= 1'b0;
            sof_p2    <= '0;
            eof_p2    <= '0;
            err_p2    <= '0;
            proto_err <= 1'b0;
        end else begin
            vld_p2    <= vld_p1;
            sof_p2    <= sof_c;
            eof_p2    <= eof_c;
            err_p2    <= err_c;
            proto_err <= proto_err | multi_c;
        end
    end

    always_ff @(posedge CLK) begin
        if (vld_p1) begin
            data_p2    <= data_p1;
            sof_pos_p2 <= sof_pos_c;
            eof_pos_p2 <= eof_pos_c;
        end
    end

    assign bus.TX_MFB_DATA    = data_p2;
    assign bus.TX_MFB_SOF     = sof_p2;
    assign bus.TX_MFB_EOF     = eof_p2;
    assign bus.TX_MFB_SOF_POS = sof_pos_p2;
    assign bus.TX_MFB_EOF_POS = eof_pos_p2;
    assign bus.TX_MFB_ERROR   = err_p2;
    assign bus.TX_MFB_SRC_RDY = vld_p2;
    assign PROTO_ERR          = proto_err;

`ifdef MAC_SEG_RX_STATS_EN
    localparam int CNT_W = $clog2(REGIONS + 1);
    logic [CNT_W-1:0] n_eof, n_err;
    logic [63:0]      cnt_frames, cnt_errors;

    // Counted from the stage-2 inputs so totals move together with the output.
    always_comb begin
        n_eof = '0;
        n_err = '0;
        for (int r = 0; r < REGIONS; r++) begin
            n_eof = n_eof + CNT_W'(eof_c[r]);
            n_err = n_err + CNT_W'(err_c[r]);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_frames <= '0;
            cnt_errors <= '0;
        end else if (CNT_CLEAR) begin
            cnt_frames <= '0;
            cnt_errors <= '0;
        end else begin
            cnt_frames <= cnt_frames + 64'(n_eof);
            cnt_errors <= cnt_errors + 64'(n_err);
        end
    end

    assign CNT_FRAMES = cnt_frames;
    assign CNT_ERRORS = cnt_errors;
`endif
endmodule
